// File: rtl/reg_file_gen.sv
// Parametrised general-purpose register file with NRD combinational read ports, one write port,
// optional write bypass, hard-wired zero entry, per-entry pending bits and a sequential clear engine.
module reg_file_gen #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rstB,
    input  logic                          wrEn,
    input  logic [$clog2(DEPTH)-1:0]      wrAddr,
    input  logic [XLEN-1:0]               wrData,
    input  logic [NRD*$clog2(DEPTH)-1:0]  rdAddr,
    output logic [NRD*XLEN-1:0]           rdData,
    output logic [NRD-1:0]                rdPend,
    input  logic                          resvEn,
    input  logic [$clog2(DEPTH)-1:0]      resvAddr,
    input  logic                          clrReq,
    output logic                          clrBusy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W  = DEPTH[AW:0];
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [AW-1:0]       clr_idx_r;
    logic                clr_busy_s;
    logic [XLEN-1:0]     mem_r [DEPTH];
    logic [DEPTH-1:0]    pend_r;
    logic                mem_we_s;
    logic [AW-1:0]       mem_waddr_s;
    logic [XLEN-1:0]     mem_wdata_s;
    logic                wr_ok_s;
    logic                resv_ok_s;

    // An index is usable when it is inside the array and is not the hard-wired zero entry
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // State register; any reset restarts the clear engine
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_idx_r == LAST_IDX) state_next_s = ST_IDLE;
                else                       state_next_s = ST_CLEAR;
            end
            ST_IDLE: begin
                if (clrReq) state_next_s = ST_CLEAR;
                else        state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_CLEAR;
        endcase
    end

    // FSM outputs
    always_comb begin
        clr_busy_s = 1'b1;
        case (state_r)
            ST_CLEAR: clr_busy_s = 1'b1;
            ST_IDLE:  clr_busy_s = 1'b0;
            default:  clr_busy_s = 1'b1;
        endcase
    end

    assign clrBusy = clr_busy_s;

    // A clear request on the same edge swallows any write or reserve
    always_comb begin
        wr_ok_s   = 1'b0;
        resv_ok_s = 1'b0;
        if (!clr_busy_s && !clrReq) begin
            wr_ok_s   = wrEn && addr_ok(wrAddr);
            resv_ok_s = resvEn && addr_ok(resvAddr);
        end else begin
            wr_ok_s   = 1'b0;
            resv_ok_s = 1'b0;
        end
    end

    // Clear index walks the array once per clear pass
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            clr_idx_r <= '0;
        end else if (state_r == ST_CLEAR) begin
            clr_idx_r <= (clr_idx_r == LAST_IDX) ? '0 : clr_idx_r + AW'(1);
        end else if (clrReq) begin
            clr_idx_r <= '0;
        end else begin
            clr_idx_r <= clr_idx_r;
        end
    end

    // Single array write port shared by the clear engine and the architectural write
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_idx_r;
        mem_wdata_s = '0;
        if (clr_busy_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_idx_r;
            mem_wdata_s = '0;
        end else if (wr_ok_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wrAddr;
            mem_wdata_s = wrData;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Pending bits; the reserve is assigned last so it beats a same-index write
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            pend_r <= '0;
        end else if (clr_busy_s || clrReq) begin
            pend_r <= '0;
        end else begin
            if (wr_ok_s)   pend_r[wrAddr]   <= 1'b0;
            if (resv_ok_s) pend_r[resvAddr] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   rd_a_s;
        logic [XLEN-1:0] rd_data_s;
        logic            rd_pend_s;

        assign rd_a_s = rdAddr[p*AW +: AW];

        // Read port priority: clear, illegal index, bypass, array
        always_comb begin
            rd_data_s = '0;
            rd_pend_s = 1'b0;
            if (clr_busy_s) begin
                rd_data_s = '0;
                rd_pend_s = 1'b0;
            end else if (!addr_ok(rd_a_s)) begin
                rd_data_s = '0;
                rd_pend_s = 1'b0;
            end else if ((BYPASS != 0) && wr_ok_s && (rd_a_s == wrAddr)) begin
                rd_data_s = wrData;
                rd_pend_s = resv_ok_s && (resvAddr == rd_a_s);
            end else begin
                rd_data_s = mem_r[rd_a_s];
                rd_pend_s = pend_r[rd_a_s];
            end
        end

        assign rdData[p*XLEN +: XLEN] = rd_data_s;
        assign rdPend[p]              = rd_pend_s;
    end

endmodule

// File: tb/tb_reg_file_gen.sv
// Directed bench for reg_file_gen: one instance with bypass, one without, driven by the same stimulus.
module tb_reg_file_gen;
    logic        clk = 1'b0;
    logic        rst_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic        resv_en;
    logic [4:0]  resv_addr;
    logic        clr_req;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_pend_b, rd_pend_n;
    logic        busy_b, busy_n;
    int          total = 0;
    int          bad   = 0;
    int          n;

    reg_file_gen #(.BYPASS(1)) dut_b (
        .clk(clk), .rstB(rst_b), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
        .rdAddr(rd_addr), .rdData(rd_data_b), .rdPend(rd_pend_b),
        .resvEn(resv_en), .resvAddr(resv_addr), .clrReq(clr_req), .clrBusy(busy_b)
    );

    reg_file_gen #(.BYPASS(0)) dut_n (
        .clk(clk), .rstB(rst_b), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
        .rdAddr(rd_addr), .rdData(rd_data_n), .rdPend(rd_pend_n),
        .resvEn(resv_en), .resvAddr(resv_addr), .clrReq(clr_req), .clrBusy(busy_n)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        resv_en = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_b) break;
            step();
            cnt++;
        end
    endtask

    initial begin
        rst_b = 1'b0;
        idle_inputs();
        wr_addr = 5'd0; wr_data = 32'h0; resv_addr = 5'd0;
        set_rd(5'd5, 5'd3);
        #12;
        chk("rst_busy_b", {63'd0, busy_b}, 64'd1);
        chk("rst_busy_n", {63'd0, busy_n}, 64'd1);
        chk("rst_rd_zero", rd_data_b, 64'd0);
        chk("rst_pend_zero", {62'd0, rd_pend_b}, 64'd0);

        rst_b = 1'b1;
        #1;
        chk("rel_busy", {63'd0, busy_b}, 64'd1);
        count_busy(n);
        chk("rst_clear_len", 64'(n), 64'd32);
        chk("rst_busy_n_done", {63'd0, busy_n}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            set_rd(i[4:0], 5'd0);
            #1;
            chk("init_data", rd_data_b[31:0], 64'd0);
            chk("init_pend", {63'd0, rd_pend_b[0]}, 64'd0);
        end

        // Plain write and two-port read
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        set_rd(5'd5, 5'd0);
        #1;
        chk("wr5_p0_b", rd_data_b[31:0], 64'hDEADBEEF);
        chk("wr5_p0_n", rd_data_n[31:0], 64'hDEADBEEF);
        chk("wr5_p1_x0", rd_data_b[63:32], 64'd0);

        // Zero register ignores writes, even on the bypass path
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        #1;
        chk("x0_bypass", rd_data_b[63:32], 64'd0);
        step();
        idle_inputs();
        #1;
        chk("x0_after", rd_data_n[63:32], 64'd0);

        // Bypass versus registered visibility
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        set_rd(5'd7, 5'd5);
        #1;
        chk("byp_new", rd_data_b[31:0], 64'hA5A5A5A5);
        chk("nobyp_old", rd_data_n[31:0], 64'd0);
        step();
        idle_inputs();
        #1;
        chk("nobyp_next", rd_data_n[31:0], 64'hA5A5A5A5);

        // Scoreboard
        resv_en = 1'b1; resv_addr = 5'd9;
        set_rd(5'd9, 5'd0);
        #1;
        chk("resv_pre", {63'd0, rd_pend_b[0]}, 64'd0);
        step();
        idle_inputs();
        #1;
        chk("resv_pend_b", {63'd0, rd_pend_b[0]}, 64'd1);
        chk("resv_pend_n", {63'd0, rd_pend_n[0]}, 64'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        #1;
        chk("wr9_byp_pend", {63'd0, rd_pend_b[0]}, 64'd0);
        chk("wr9_byp_data", rd_data_b[31:0], 64'h11);
        chk("wr9_nobyp_pend", {63'd0, rd_pend_n[0]}, 64'd1);
        step();
        idle_inputs();
        #1;
        chk("wr9_pend", {62'd0, rd_pend_b[0], rd_pend_n[0]}, 64'd0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h22;
        resv_en = 1'b1; resv_addr = 5'd9;
        #1;
        chk("both9_byp_pend", {63'd0, rd_pend_b[0]}, 64'd1);
        chk("both9_byp_data", rd_data_b[31:0], 64'h22);
        step();
        idle_inputs();
        #1;
        chk("both9_data", {rd_data_b[31:0], rd_data_n[31:0]}, {32'h22, 32'h22});
        chk("both9_pend", {62'd0, rd_pend_b[0], rd_pend_n[0]}, 64'd3);
        resv_en = 1'b1; resv_addr = 5'd0;
        step();
        idle_inputs();
        set_rd(5'd0, 5'd9);
        #1;
        chk("x0_never_pend", {63'd0, rd_pend_b[0]}, 64'd0);

        // Requested clear, with a dropped write and a second request mid-clear
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        step();
        idle_inputs();
        set_rd(5'd3, 5'd4);
        #1;
        chk("x3_pre_clear", rd_data_n[31:0], 64'h55);
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
        step();
        idle_inputs();
        chk("clr_busy", {63'd0, busy_b}, 64'd1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_b) break;
            if (n == 5) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99;
                #1;
                chk("clr_rd_zero", rd_data_b[31:0], 64'd0);
            end
            if (n == 10) clr_req = 1'b1;
            step();
            n++;
            idle_inputs();
        end
        chk("clr_len", 64'(n), 64'd32);
        set_rd(5'd3, 5'd4);
        #1;
        chk("x3_cleared", rd_data_b[31:0], 64'd0);
        chk("x4_dropped", rd_data_n[63:32], 64'd0);
        set_rd(5'd9, 5'd5);
        #1;
        chk("x9_pend_cleared", {62'd0, rd_pend_b[0], rd_pend_n[0]}, 64'd0);
        chk("x5_cleared", rd_data_b[63:32], 64'd0);

        // Async reset in the middle of a clear restarts the full pass
        clr_req = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) step();
        #3;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy_b}, 64'd1);
        step();
        #2;
        rst_b = 1'b1;
        #1;
        count_busy(n);
        chk("mid_rst_len", 64'(n), 64'd32);
        chk("mid_rst_busy_n", {63'd0, busy_n}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
